// File: rtl/remote_throw_rx.sv
// Purpose : receive side of the board-to-board throw link; turns the peer's asynchronous throw flag and power bus into one clean capture pulse.
// Latency : remote_throw/remote_busy rise SYNC_STAGES+STABLE_CYCLES edges after the first edge that samples the flag high (power already steady).
// Backpr. : none; the peer cannot be stalled, so throws that are not allowed or not clean are dropped (with link_error for faults).
//
// Ports:
//   clk60MHz, rst (async, active low)  - clock and reset
//   enable                             - remote player owns the current turn
//   in_throw_flag, in_power[4:0]       - peer pins, asynchronous to clk60MHz
//   clr_error                          - clears link_error unless a fault happens in the same cycle
//   remote_power[4:0]                  - power of the last accepted throw
//   remote_throw                       - one-cycle acceptance pulse
//   remote_busy                        - accepted flag still held high by the peer
//   link_error                         - sticky fault flag (glitch or settle timeout)
module remote_throw_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk60MHz,
    input  logic       rst,
    input  logic       enable,
    input  logic       in_throw_flag,
    input  logic [4:0] in_power,
    input  logic       clr_error,
    output logic [4:0] remote_power,
    output logic       remote_throw,
    output logic       remote_busy,
    output logic       link_error
);

    // The timeout counter also times the post-reset wait, so it must hold both ranges.
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + SYNC_STAGES + 1);
    localparam int ST_W = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_IDLE,
        ST_CAPTURE,
        ST_HOLD,
        ST_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0]      flag_sync_q, flag_sync_d;
    logic [SYNC_STAGES-1:0][4:0] pwr_sync_q, pwr_sync_d;
    logic                        flag_p_q, flag_p_d;
    logic [4:0]                  pwr_p_q, pwr_p_d;
    state_t                      state_q, state_d;
    logic [ST_W-1:0]             stab_cnt_q, stab_cnt_d;
    logic [TO_W-1:0]             to_cnt_q, to_cnt_d;
    logic [4:0]                  remote_power_q, remote_power_d;
    logic                        remote_throw_q, remote_throw_d;
    logic                        remote_busy_q, remote_busy_d;
    logic                        link_error_q, link_error_d;

    logic       flag_s;
    logic [4:0] power_s;
    logic       flag_rise;
    logic       pwr_same;
    logic       fault;

    assign flag_s    = flag_sync_q[SYNC_STAGES-1];
    assign power_s   = pwr_sync_q[SYNC_STAGES-1];
    assign flag_rise = flag_s & ~flag_p_q;
    assign pwr_same  = (power_s == pwr_p_q);

    always_comb begin
        flag_sync_d    = {flag_sync_q[SYNC_STAGES-2:0], in_throw_flag};
        pwr_sync_d     = {pwr_sync_q[SYNC_STAGES-2:0], in_power};
        flag_p_d       = flag_s;
        pwr_p_d        = power_s;
        state_d        = state_q;
        stab_cnt_d     = stab_cnt_q;
        to_cnt_d       = to_cnt_q;
        remote_power_d = remote_power_q;
        remote_throw_d = 1'b0;
        fault          = 1'b0;

        unique case (state_q)
            ST_STARTUP: begin
                // Let the synchronisers flush; a flag already high here belongs
                // to a throw that started before we were alive, so skip it.
                if (to_cnt_q == TO_W'(SYNC_STAGES)) begin
                    to_cnt_d = '0;
                    state_d  = flag_s ? ST_IGNORE : ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (flag_rise) begin
                    state_d    = enable ? ST_CAPTURE : ST_IGNORE;
                    stab_cnt_d = '0;
                    to_cnt_d   = '0;
                end
            end
            ST_CAPTURE: begin
                to_cnt_d   = to_cnt_q + 1'b1;
                stab_cnt_d = pwr_same ? stab_cnt_q + 1'b1 : '0;
                // Priority: flag glitch, then settle timeout, then capture.
                if (!flag_s) begin
                    fault   = 1'b1;
                    state_d = ST_IDLE;
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    fault   = 1'b1;
                    state_d = ST_IGNORE;
                end else if (pwr_same && (stab_cnt_q == ST_W'(STABLE_CYCLES - 1))) begin
                    remote_power_d = power_s;
                    remote_throw_d = 1'b1;
                    state_d        = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!flag_s) state_d = ST_IDLE;
            end
            ST_IGNORE: begin
                if (!flag_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A new fault wins over a simultaneous clear.
        if (fault)          link_error_d = 1'b1;
        else if (clr_error) link_error_d = 1'b0;
        else                link_error_d = link_error_q;

        remote_busy_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk60MHz or negedge rst) begin
        if (!rst) begin
            flag_sync_q    <= '0;
            pwr_sync_q     <= '0;
            flag_p_q       <= 1'b0;
            pwr_p_q        <= '0;
            state_q        <= ST_STARTUP;
            stab_cnt_q     <= '0;
            to_cnt_q       <= '0;
            remote_power_q <= '0;
            remote_throw_q <= 1'b0;
            remote_busy_q  <= 1'b0;
            link_error_q   <= 1'b0;
        end else begin
            flag_sync_q    <= flag_sync_d;
            pwr_sync_q     <= pwr_sync_d;
            flag_p_q       <= flag_p_d;
            pwr_p_q        <= pwr_p_d;
            state_q        <= state_d;
            stab_cnt_q     <= stab_cnt_d;
            to_cnt_q       <= to_cnt_d;
            remote_power_q <= remote_power_d;
            remote_throw_q <= remote_throw_d;
            remote_busy_q  <= remote_busy_d;
            link_error_q   <= link_error_d;
        end
    end

    assign remote_power = remote_power_q;
    assign remote_throw = remote_throw_q;
    assign remote_busy  = remote_busy_q;
    assign link_error   = link_error_q;

endmodule

// File: doc/remote_throw_rx.md
Name: remote_throw_rx

Overview:
- Receive side of the board-to-board throw link. The local throw logic drives out_throw_flag/out_power; this block reads the peer's in_throw_flag/in_power.
- The peer runs on an unrelated clock, so the block synchronises both inputs and waits for the power bus to settle.
- For each valid remote throw it emits one clean capture pulse with the latched power.
- Sits between the board pins and the turn/particle logic, in the clk60MHz domain.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on in_throw_flag and each in_power bit (min 2)
- STABLE_CYCLES, 4, consecutive unchanged synchronised power samples required before capture (min 1)
- TIMEOUT_CYCLES, 1024, max cycles spent waiting for a stable power bus

Ports:
- clk60MHz  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- enable  in  1  high when the remote player owns the current turn
- in_throw_flag  in  1  peer throw flag, asynchronous
- in_power  in  5  peer throw power, asynchronous
- clr_error  in  1  clears link_error (synchronous)
- remote_power  out  5  latched power of the last accepted throw
- remote_throw  out  1  one-cycle pulse on throw acceptance
- remote_busy  out  1  high while an accepted throw flag is still held by the peer
- link_error  out  1  sticky fault flag

Behaviour:
- Reset (rst=0, asynchronous)
  - All outputs 0, all synchroniser flops 0, stability counter 0, timeout counter 0, state STARTUP.
- Synchronisation
  - flag_s and power_s are the outputs of the SYNC_STAGES-deep chains.
  - flag_p is flag_s delayed by one cycle.
  - A rise is flag_s=1 and flag_p=0.
- FSM, registered, one transition per clock:
  - STARTUP: wait SYNC_STAGES+1 cycles. Then go to IGNORE if flag_s=1, else IDLE. This means a flag already high at reset release never produces a throw.
  - IDLE
    - Rise with enable=1: go to CAPTURE; clear the stability and timeout counters.
    - Rise with enable=0: go to IGNORE; no pulse, no error.
  - CAPTURE
    - Each cycle: timeout counter +1.
    - If power_s equals its previous-cycle value, stability counter +1; otherwise the stability counter goes to 0.
    - Stability counter reaching STABLE_CYCLES-1 with power unchanged this cycle: latch remote_power<=power_s, pulse remote_throw=1 for exactly one cycle, go to HOLD.
    - flag_s=0 before capture (glitch): link_error<=1, go to IDLE, no pulse.
    - Timeout counter reaching TIMEOUT_CYCLES-1: link_error<=1, go to IGNORE, no pulse.
    - enable falling while in CAPTURE does not abort the capture.
  - HOLD: remote_busy=1. When flag_s=0, go to IDLE. Power changes are ignored and remote_power is held.
  - IGNORE: when flag_s=0, go to IDLE. Outputs unchanged.
- Latency (power constant before the flag rises)
  - remote_throw is high on the cycle after clock edge number SYNC_STAGES+STABLE_CYCLES+1, counted from the first edge that samples in_throw_flag=1. With defaults this is edge 7.
  - remote_busy rises on the same edge as remote_throw.
  - remote_busy falls SYNC_STAGES+1 edges after the pin falls.
- Power value rules
  - remote_power changes only on acceptance.
  - Power 0 is a valid value and is accepted.
- link_error
  - Set-dominant: if clr_error and a new fault occur in the same cycle, link_error stays 1.
  - Otherwise clr_error=1 clears it on the next edge.
  - link_error does not block further throws.
- Simultaneous events in CAPTURE: glitch has priority over timeout, and timeout has priority over capture.
- Reset asserted mid-operation: immediate return to the reset values listed above, including remote_power=0.

Test Plan:
- Reset release with pin flag=0, then enable=1, power=5'd17 steady, flag high 20 cycles → remote_throw exactly 1 cycle at edge 7 after the first high sample; remote_power=17; remote_busy high until 3 edges after the flag falls; link_error=0.
- Flag high with enable=0, power=9 → no remote_throw; remote_power keeps its prior value. A second throw (enable=1, power=3) after the flag drops is accepted with remote_power=3.
- Power toggling every 2 cycles between 5 and 6 for 30 cycles, then steady 6 → exactly one pulse, 4 stable cycles after the last change, with remote_power=6.
- Flag pulse 3 cycles wide while power is toggling → link_error=1, no pulse. Then clr_error=1 for 1 cycle → link_error=0.
- TIMEOUT_CYCLES=16, power toggling every cycle, flag held high → link_error=1 after 16 CAPTURE cycles, no pulse. The block stays in IGNORE until the flag drops, then a clean throw is accepted.
- Pin flag high during reset and still high at release → no pulse. rst pulsed low during HOLD → all outputs 0 immediately.
